// File: rtl/scmp_sio_pak.sv
// Shared types and constants for the SC/MP extension-register serial port.
package scmp_sio_pak;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } SIO_STATE_t;

  localparam int unsigned SIO_BITS        = 8;
  localparam int unsigned SIO_CLK_DIV_DEF = 16;

endpackage

// File: rtl/scmp_sio_baud.sv
// Bit-period down-counter: loads CLK_DIV-1, ticks on reaching zero and reloads on the same cycle.
module scmp_sio_baud #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || tick_o)
      cnt_d = RELOAD;
    else if (run_i)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scmp_sio_port.sv
// SC/MP E register with SIN/SOUT: manual SIO shifting plus a self-timed 8-bit burst.
// Define SCMP_SIO_FRAME_EN to add UART 8N1 start/stop framing and frame_err.
module scmp_sio_port
  import scmp_sio_pak::*;
#(
  parameter int unsigned CLK_DIV = SIO_CLK_DIV_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                e_ld,
  input  logic [SIO_BITS-1:0] e_din,
  output logic [SIO_BITS-1:0] e_dout,
  input  logic                sio_strb,
  input  logic                burst_go,
  output logic                busy,
  output logic                done,
  output logic                frame_err,
  input  logic                sin,
  output logic                sout
);

  SIO_STATE_t          state_q;
  logic [SIO_BITS-1:0] e_q;
  logic [2:0]          bit_cnt_q;
  logic [1:0]          sync_q;
  logic                sout_q, busy_q, done_q;
  logic                sin_s, tick, baud_load, baud_run;
  logic [SIO_BITS-1:0] e_shift;

  assign sin_s     = sync_q[1];
  assign e_shift   = {sin_s, e_q[SIO_BITS-1:1]};
  assign baud_load = (state_q == IDLE) && burst_go && !e_ld;
  assign baud_run  = state_q inside {START, DATA, STOP};

  scmp_sio_baud #(
    .CNT_W  (CNT_W),
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .load_i(baud_load),
    .run_i (baud_run),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (rst)
      sync_q <= '1;
    else
      sync_q <= {sync_q[0], sin};
  end

`ifdef SCMP_SIO_FRAME_EN
  logic frame_err_q;
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      e_q       <= '0;
      bit_cnt_q <= '0;
      sout_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SCMP_SIO_FRAME_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (e_ld) begin
            e_q <= e_din;
          end else if (burst_go) begin
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
`ifdef SCMP_SIO_FRAME_EN
            sout_q      <= 1'b0;
            frame_err_q <= 1'b0;
            state_q     <= START;
`else
            sout_q  <= e_q[0];
            state_q <= DATA;
`endif
          end else if (sio_strb) begin
            sout_q <= e_q[0];
            e_q    <= e_shift;
          end
        end
`ifdef SCMP_SIO_FRAME_EN
        START: begin
          if (tick) begin
            sout_q  <= e_q[0];
            state_q <= DATA;
          end
        end
`endif
        DATA: begin
          if (tick) begin
            e_q       <= e_shift;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(SIO_BITS - 1)) begin
`ifdef SCMP_SIO_FRAME_EN
              sout_q  <= 1'b1;
              state_q <= STOP;
`else
              sout_q  <= e_q[1];
              state_q <= DONE;
`endif
            end else begin
              sout_q <= e_q[1];
            end
          end
        end
`ifdef SCMP_SIO_FRAME_EN
        STOP: begin
          if (tick) begin
            frame_err_q <= ~sin_s;
            state_q     <= DONE;
          end
        end
`endif
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          sout_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign e_dout = e_q;
  assign sout   = sout_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
